oh_scanctrl: RTL and testbench

OH_SCANCTRL -- requirements
Module: oh_scanctrl

---
 rtl/oh_scanctrl.sv | 147 ++++++++++++++
 tb/tb_oh_scanctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oh_scanctrl.sv
// Scan-test controller: serially loads a pattern into an N-flop scan chain,
// pulses one capture cycle, unloads the response and compares it under a mask.
module oh_scanctrl #(
  parameter int N  = 32,
  parameter int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] pattern,
  input  logic [N-1:0] expected,
  input  logic [N-1:0] mask,
  output logic         se,
  output logic         si,
  input  logic         so,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] response
);

  typedef enum logic [2:0] {IDLE, LOAD, CAPT, UNLOAD, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  pat_q, pat_d, exp_q, exp_d, msk_q, msk_d;
  logic [N-1:0]  rsh_q, rsh_d, resp_q, resp_d;
  logic          se_q, se_d, si_q, si_d, busy_q, busy_d;
  logic          done_q, done_d, pass_q, pass_d;
  logic [N-1:0]  ld_sh, cap_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    msk_d   = msk_q;
    rsh_d   = rsh_q;
    resp_d  = resp_q;
    se_d    = se_q;
    si_d    = si_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    // Outputs are registered, so si for the next LOAD cycle is the bit after
    // the one currently on the wire: pattern[N-2-cnt].
    ld_sh   = pat_q << (cnt_q + CW'(1));
    cap_d   = {rsh_q[N-2:0], so};
    case (state_q)
      IDLE: begin
        se_d   = 1'b0;
        si_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          pat_d   = pattern;
          exp_d   = expected;
          msk_d   = mask;
          cnt_d   = '0;
          state_d = LOAD;
          se_d    = 1'b1;
          si_d    = pattern[N-1];
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        si_d = ld_sh[N-1];
        if (cnt_q == LAST) begin
          state_d = CAPT;
          se_d    = 1'b0;
          si_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPT: begin
        state_d = UNLOAD;
        se_d    = 1'b1;
        si_d    = 1'b0;
        cnt_d   = '0;
      end
      UNLOAD: begin
        rsh_d = cap_d;
        if (cnt_q == LAST) begin
          state_d = DONE;
          se_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          resp_d  = cap_d;
          pass_d  = ~|((cap_d ^ exp_q) & msk_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      msk_q   <= '0;
      rsh_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      msk_q   <= msk_d;
      rsh_q   <= rsh_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign se       = se_q;
  assign si       = si_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign response = resp_q;

endmodule

// File: tb/tb_oh_scanctrl.sv
// Directed bench for oh_scanctrl: N=4 and N=32 instances, each driving a
// behavioural scan chain (q <= se ? si : d).
module tb_oh_scanctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=4 instance and its chain
  logic [3:0] pat4, exp4, msk4, d4, resp4, chain4;
  logic       start4, se4, si4, so4, busy4, done4, pass4;
  int         done_cnt4;

  oh_scanctrl #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .pattern(pat4), .expected(exp4),
    .mask(msk4), .se(se4), .si(si4), .so(so4), .busy(busy4), .done(done4),
    .pass(pass4), .response(resp4)
  );

  assign so4 = chain4[3];
  always @(posedge clk) chain4 <= se4 ? {chain4[2:0], si4} : d4;
  always @(posedge clk) if (reset) done_cnt4 <= 0; else if (done4) done_cnt4 <= done_cnt4 + 1;

  // N=32 instance and its chain
  logic [31:0] pat32, exp32, msk32, d32, resp32, chain32;
  logic        start32, se32, si32, so32, busy32, done32, pass32;

  oh_scanctrl #(.N(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .pattern(pat32), .expected(exp32),
    .mask(msk32), .se(se32), .si(si32), .so(so32), .busy(busy32), .done(done32),
    .pass(pass32), .response(resp32)
  );

  assign so32 = chain32[31];
  always @(posedge clk) chain32 <= se32 ? {chain32[30:0], si32} : d32;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one N=4 test from the current (IDLE) cycle; optionally pulses start
  // again in cycle ign_at. Returns one cycle after done (back in IDLE).
  task automatic run4(input logic [3:0] p, input logic [3:0] e, input logic [3:0] m,
                      input int ign_at, output logic [3:0] r, output logic ps,
                      output int dc);
    pat4 = p; exp4 = e; msk4 = m; start4 = 1'b1;
    dc = -1; r = 'x; ps = 1'bx;
    tick();
    for (int c = 1; c <= 14; c++) begin
      start4 = (c == ign_at);
      if (done4 === 1'b1) begin
        r = resp4; ps = pass4; dc = c;
        start4 = 1'b0;
        tick();
        break;
      end
      tick();
    end
    start4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start4 = 1'b0; start32 = 1'b0;
    tick(); tick();
    checks++;
    if ({busy4, done4, se4, si4, pass4} !== 5'b0 || resp4 !== 4'h0) begin
      errors++;
      $display("FAIL reset_state4: busy/done/se/si/pass=%b response=%h, want 00000 and 0",
               {busy4, done4, se4, si4, pass4}, resp4);
    end
    checks++;
    if ({busy32, done32, se32, pass32} !== 4'b0 || resp32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state32: busy/done/se/pass=%b response=%h, want 0000 and 0",
               {busy32, done32, se32, pass32}, resp32);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] si_exp;
    si_exp = 4'b1010;
    pat4 = 4'b1010; exp4 = 4'b0110; msk4 = 4'b1111; d4 = 4'b0110;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 4) begin
        checks++;
        if (si4 !== si_exp[4-c]) begin
          errors++;
          $display("FAIL basic_si t%0d: got %b want %b", c, si4, si_exp[4-c]);
        end
      end
      checks++;
      if (se4 !== (c != 5 && c != 10)) begin
        errors++;
        $display("FAIL basic_se t%0d: got %b want %b", c, se4, (c != 5 && c != 10));
      end
      checks++;
      if (busy4 !== (c <= 9) || done4 !== (c == 10)) begin
        errors++;
        $display("FAIL basic_busy_done t%0d: busy=%b done=%b want %b %b",
                 c, busy4, done4, (c <= 9), (c == 10));
      end
      if (c == 5) begin
        checks++;
        if (chain4 !== 4'b1010) begin
          errors++;
          $display("FAIL basic_chain_loaded: got %b want 1010", chain4);
        end
      end
      if (c == 10) begin
        checks++;
        if (resp4 !== 4'b0110 || pass4 !== 1'b1) begin
          errors++;
          $display("FAIL basic_result: response=%b pass=%b want 0110 1", resp4, pass4);
        end
      end
      tick();
    end
    checks++;
    if (done4 !== 1'b0 || resp4 !== 4'b0110 || pass4 !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: done=%b response=%b pass=%b want 0 0110 1", done4, resp4, pass4);
    end
  endtask

  task automatic test_compare();
    logic [3:0] r;
    logic       ps;
    int         dc;
    d4 = 4'b0110;
    run4(4'b1010, 4'b0111, 4'b1111, 0, r, ps, dc);
    checks++;
    if (dc != 10 || r !== 4'b0110 || ps !== 1'b0) begin
      errors++;
      $display("FAIL compare_mismatch: done_t=%0d response=%b pass=%b want 10 0110 0", dc, r, ps);
    end
    run4(4'b1010, 4'b0111, 4'b1110, 0, r, ps, dc);
    checks++;
    if (dc != 10 || r !== 4'b0110 || ps !== 1'b1) begin
      errors++;
      $display("FAIL compare_masked: done_t=%0d response=%b pass=%b want 10 0110 1", dc, r, ps);
    end
    d4 = 4'b1001;
    run4(4'b0011, 4'b1001, 4'b1111, 0, r, ps, dc);
    checks++;
    if (dc != 10 || r !== 4'b1001 || ps !== 1'b1) begin
      errors++;
      $display("FAIL compare_alt_d: done_t=%0d response=%b pass=%b want 10 1001 1", dc, r, ps);
    end
    d4 = 4'b0110;
  endtask

  task automatic test_back_to_back();
    logic [3:0] r;
    logic       ps;
    int         dc, base;
    base = done_cnt4;
    run4(4'b1010, 4'b0110, 4'b1111, 3, r, ps, dc);
    checks++;
    if (dc != 10 || done_cnt4 != base + 1 || r !== 4'b0110 || ps !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: done_t=%0d dones=%0d response=%b pass=%b want 10 %0d 0110 1",
               dc, done_cnt4, r, ps, base + 1);
    end
    run4(4'b0101, 4'b0000, 4'b1111, 0, r, ps, dc);
    checks++;
    if (dc != 10 || r !== 4'b0110 || ps !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: done_t=%0d response=%b pass=%b want 10 0110 0", dc, r, ps);
    end
    repeat (12) tick();
    checks++;
    if (done_cnt4 != base + 2 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL spurious_done: dones=%0d busy=%b want %0d 0", done_cnt4, busy4, base + 2);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    pat4 = 4'b1010; exp4 = 4'b0110; msk4 = 4'b1111;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy4, se4, done4, pass4} !== 4'b0 || resp4 !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: busy/se/done/pass=%b response=%b want 0000 0000",
               {busy4, se4, done4, pass4}, resp4);
    end
    base = done_cnt4;
    repeat (10) tick();
    checks++;
    if (done_cnt4 != base || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d busy=%b want %0d 0", done_cnt4, busy4, base);
    end
    reset = 1'b1; start4 = 1'b1;
    tick();
    reset = 1'b0; start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b0 || se4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b se=%b want 0 0", busy4, se4);
    end
    tick();
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start_idle: busy=%b want 0", busy4);
    end
  endtask

  task automatic test_n32();
    int dc;
    logic [31:0] r;
    logic        ps;
    dc = -1; r = 'x; ps = 1'bx;
    pat32 = $urandom; d32 = ~pat32; exp32 = ~pat32; msk32 = '1;
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (done32 === 1'b1) begin
        dc = c; r = resp32; ps = pass32;
        break;
      end
      tick();
    end
    checks++;
    if (dc != 66) begin
      errors++;
      $display("FAIL n32_latency: done_t=%0d want 66", dc);
    end
    checks++;
    if (r !== ~pat32 || ps !== 1'b1) begin
      errors++;
      $display("FAIL n32_result: response=%h pass=%b want %h 1", r, ps, ~pat32);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; start4 = 1'b0; start32 = 1'b0;
    pat4 = '0; exp4 = '0; msk4 = '0; d4 = 4'b0110; chain4 = '0;
    pat32 = '0; exp32 = '0; msk32 = '0; d32 = '0; chain32 = '0;
    test_reset();
    test_basic();
    test_compare();
    test_back_to_back();
    test_reset_mid();
    test_n32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
